// File: rtl/m20k_fifo_ctrl.sv
// Ready/valid byte FIFO built on a 2048x8 dual-port M20K: port 0 writes, port 1 reads.
// Latency: a push reaches out_valid 3 cycles later (1-cycle RAM read plus output-buffer capture).
// Backpressure: in_ready drops only when count == DEPTH; the 2-entry output buffer absorbs the read pipeline.
module m20k_fifo_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              CE0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic [ADDR_W-1:0] A1,
    output logic              CE1,
    output logic              WE1,
    output logic [DATA_W-1:0] D1,
    output logic [DATA_W-1:0] WEM1,
    input  logic [DATA_W-1:0] Q1
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   ram_cnt;
    logic [1:0]        ob_cnt;
    logic              inflight;
    logic [DATA_W-1:0] ob_head;
    logic [DATA_W-1:0] ob_tail;
    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        ob_occ;

    assign in_ready  = !RST && (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob_head;
    assign pop       = out_valid && out_ready;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

    // Only issue a read if the buffer will still have a free slot when the data lands.
    assign ob_occ = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = !RST && (ram_cnt != '0) && (ob_occ < 3'd2);

    assign A0   = wptr;
    assign D0   = in_data;
    assign CE0  = push;
    assign WE0  = push;
    assign WEM0 = '1;
    assign A1   = rptr;
    assign CE1  = issue;
    assign WE1  = 1'b0;
    assign D1   = '0;
    assign WEM1 = '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            count    <= '0;
            ob_cnt   <= 2'd0;
            inflight <= 1'b0;
            ob_head  <= '0;
            ob_tail  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (issue) begin
                rptr <= rptr + ADDR_W'(1);
            end
            ram_cnt  <= ram_cnt + {ADDR_W'(0), push} - {ADDR_W'(0), issue};
            count    <= count + {ADDR_W'(0), push} - {ADDR_W'(0), pop};
            inflight <= issue;

            // Returning read data goes to whichever slot is the tail after this cycle's pop.
            case ({pop, inflight})
                2'b10: begin
                    ob_head <= ob_tail;
                    ob_cnt  <= ob_cnt - 2'd1;
                end
                2'b01: begin
                    if (ob_cnt == 2'd0) begin
                        ob_head <= Q1;
                    end else begin
                        ob_tail <= Q1;
                    end
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob_head <= Q1;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= Q1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/m20k_fifo_ctrl.md
# m20k_fifo_ctrl

Synchronous FIFO controller that turns one 2048x8 dual-port M20K macro into a ready/valid byte FIFO. Sits directly upstream of the RAM: it drives port 0 as the write port and port 1 as the read port. A 2-entry output buffer hides the RAM's 1-cycle read latency, so the FIFO sustains one push and one pop per cycle.

## Interface
Parameters:
- ADDR_W, 11, RAM address width.
- DATA_W, 8, data width.
- DEPTH, 2048, FIFO capacity in entries; must equal 2^ADDR_W.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO accepts data.
- in_data  in  DATA_W  push data.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes head.
- out_data  out  DATA_W  head entry.
- count  out  ADDR_W+1  entries held, 0..DEPTH; covers RAM, in-flight read and output buffer.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- A0  out  ADDR_W  write address; equals wptr.
- D0  out  DATA_W  write data; equals in_data.
- CE0, WE0  out  1  both equal the push handshake.
- WEM0  out  DATA_W  all ones.
- A1  out  ADDR_W  read address; equals rptr.
- CE1  out  1  read issue.
- WE1  out  1  constant 0.
- D1, WEM1  out  DATA_W  constant 0.
- Q1  in  DATA_W  RAM port-1 read data; valid in the cycle after CE1.

## Operation
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = !RST & (count < DEPTH). It is a function of registers only and has no combinational path from out_ready.
- On push: write in_data at wptr. wptr increments modulo DEPTH (natural wrap 2047 -> 0). ram_cnt increments.
- Read issue: CE1 = !RST & (ram_cnt != 0) & (ob_cnt + inflight - pop < 2).
  - On issue: rptr increments modulo DEPTH, ram_cnt decrements, inflight is 1 next cycle.
  - CE1 has a combinational path from out_ready. This path is accepted.
- When inflight = 1, Q1 is written into the output buffer tail at the edge. The buffer is 2 entries, FIFO ordered.
- out_valid = (ob_cnt != 0). out_data = buffer head.
  - Both come from registers only; Q1 never bypasses to out_data.
- ram_cnt update on a simultaneous push and issue: +1 -1, net 0.
- count update: +push -pop. Simultaneous push and pop leaves count unchanged.
- Address collision on the RAM: port-0 write and port-1 read can only share an address when ram_cnt is 0 or DEPTH.
  - With ram_cnt 0, no read is issued.
  - With ram_cnt DEPTH, count is DEPTH, so no push occurs.
  - The RAM's undefined mixed-port read-during-write is therefore never exercised.
- Full (count == DEPTH): in_ready = 0. Pop alone is allowed. Push resumes the cycle after a pop.
- Empty: out_valid = 0. A pop cannot occur. A push still completes normally.

## Timing
- Reset: applied at any CLK edge where RST = 1, including mid-operation.
  - wptr, rptr, ram_cnt, ob_cnt, inflight and count all go to 0.
  - Any in-flight read is discarded.
- Outputs after reset: out_valid 0, count 0, empty 1, full 0, out_data 0.
- While RST is high: in_ready 0, CE0 0, CE1 0.
- First-word latency: push at edge E0; CE1 high in cycle 1; Q1 valid in cycle 2; captured at E2; out_valid = 1 in cycle 3.
- Steady state: with in_valid and out_ready held high, throughput is 1 entry/cycle (ob_cnt 1, inflight 1).
- Backpressure: after out_ready drops, at most 2 entries land in the output buffer. The remainder stays in RAM.

## Test plan
- Reset, then a single push of 0xA5 -> out_valid rises exactly 3 cycles after the push edge with out_data 0xA5; count goes 1 then back to 0 after the pop; empty = 1.
- 2048 pushes with out_ready = 0 -> full = 1 and in_ready = 0 after the 2048th push, count = 2048. Further in_valid is ignored. One pop -> in_ready = 1 next cycle.
- Continuous push of an incrementing byte pattern with out_ready = 1 for 5000 cycles -> output sequence is identical to input, with no bubbles after the initial latency. Covers pointer wrap 2047 -> 0 twice.
- Random in_valid/out_ready at 50% each over 20000 cycles -> order preserved and count always equals pushes minus pops. Assert CE1 never reads the address being written with WE0 in the same cycle.
- Fill with 10 entries, drop out_ready for 20 cycles, then raise it -> ob_cnt ≤ 2 throughout; data 0..9 delivered in order with no loss or duplication.
- Assert RST for 1 cycle while 5 entries are queued and a read is in flight -> next cycle count = 0, out_valid = 0, in_ready = 1. A subsequent push of 0x3C emerges as the first output.
